// File: rtl/seq_mul_4x4.sv
// Iterative unsigned shift-and-add multiplier: one WIDTH-bit add plus a right shift per cycle,
// with a start/busy/done handshake and a held 2*WIDTH-bit product.
module seq_mul_4x4 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_a;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_q_next;

    // r_c is always 0 entering a step, so the "no add" path is simply {C,A}.
    assign w_sum    = r_q[0] ? ({1'b0, r_a} + {1'b0, r_m}) : {r_c, r_a};
    assign w_a_next = w_sum[WIDTH:1];
    assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_a     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_q     <= b;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_cnt   <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Final step: capture the post-shift {A,Q} directly as the result.
                    if (r_cnt == CNT_W'(1)) begin
                        product <= {w_a_next, w_q_next};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
